// File: rtl/sdaccel_stream_pkg.sv
// Shared defaults and handshake helpers for the SDAccel stream buffers.
package sdaccel_stream_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_ADDR_WIDTH = 2;
    localparam int unsigned MAX_ADDR_WIDTH = 6;

    // AXI side: word moves when valid meets ready.
    function automatic logic xfer_axi(input logic valid, input logic ready);
        return valid && ready;
    endfunction

    // SELF side: word moves when valid and the consumer is not stopping.
    function automatic logic xfer_self(input logic valid, input logic stop);
        return valid && !stop;
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Register-array FIFO storage: one synchronous write port, one asynchronous read port.
module stream_fifo_mem #(
    parameter int unsigned DataWidth = 16,
    parameter int unsigned AddrWidth = 2
) (
    input  logic                 clk,
    input  logic                 wrEn,
    input  logic [AddrWidth-1:0] wrAddr,
    input  logic [DataWidth-1:0] wrData,
    input  logic [AddrWidth-1:0] rdAddr,
    output logic [DataWidth-1:0] rdData_c
);

    localparam int unsigned Depth = 1 << AddrWidth;

    logic [DataWidth-1:0] mem [Depth];

    // Storage is deliberately left unreset; only pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData_c = mem[rdAddr];

endmodule

// File: rtl/axi_input_buffer.sv
// AXI valid/ready to SELF valid/stop ingress buffer with a small register FIFO.
// Define AXI_INPUT_BUFFER_LEVEL_EN to expose the registered occupancy on fillLevel.
module axi_input_buffer
    import sdaccel_stream_pkg::*;
#(
    parameter int unsigned DataWidth = DEF_DATA_WIDTH,
    parameter int unsigned AddrWidth = DEF_ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 srst_n,
    input  logic                 axiValid,
    input  logic [DataWidth-1:0] axiDataIn,
    output logic                 axiReady,
    output logic                 dataOutValid,
    output logic [DataWidth-1:0] dataOut,
`ifdef AXI_INPUT_BUFFER_LEVEL_EN
    output logic [AddrWidth:0]   fillLevel,
`endif
    input  logic                 dataOutStop
);

    localparam int unsigned Depth    = 1 << AddrWidth;
    localparam int unsigned CntWidth = AddrWidth + 1;

    logic [AddrWidth-1:0] rdPtr;
    logic [AddrWidth-1:0] wrPtr;
    logic [AddrWidth-1:0] rdPtrNext;
    logic [CntWidth-1:0]  count;
    logic [CntWidth-1:0]  countNext;
    logic                 push;
    logic                 pop;
    logic                 loadFromIn;
    logic [DataWidth-1:0] memRdData;

    stream_fifo_mem #(
        .DataWidth(DataWidth),
        .AddrWidth(AddrWidth)
    ) u_mem (
        .clk     (clk),
        .wrEn    (push),
        .wrAddr  (wrPtr),
        .wrData  (axiDataIn),
        .rdAddr  (rdPtrNext),
        .rdData_c(memRdData)
    );

    // Handshakes, next pointers/count, and whether the next head is the word arriving now.
    always_comb begin
        push       = xfer_axi(axiValid, axiReady);
        pop        = xfer_self(dataOutValid, dataOutStop);
        rdPtrNext  = pop ? rdPtr + AddrWidth'(1) : rdPtr;
        countNext  = count + CntWidth'(push) - CntWidth'(pop);
        loadFromIn = push && (count == CntWidth'(pop));
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            rdPtr        <= '0;
            wrPtr        <= '0;
            count        <= '0;
            axiReady     <= 1'b0;
            dataOutValid <= 1'b0;
            dataOut      <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + AddrWidth'(1);
            end
            rdPtr        <= rdPtrNext;
            count        <= countNext;
            axiReady     <= countNext < CntWidth'(Depth);
            dataOutValid <= countNext != '0;
            // Empty keeps the last word on dataOut.
            if (loadFromIn) begin
                dataOut <= axiDataIn;
            end else if (countNext != '0) begin
                dataOut <= memRdData;
            end
        end
    end

`ifdef AXI_INPUT_BUFFER_LEVEL_EN
    assign fillLevel = count;
`endif

endmodule

// File: tb/tb_axi_input_buffer.sv
// Self-checking bench for axi_input_buffer: directed vector table plus queue-model random streaming.
`timescale 1ns/1ps
module tb_axi_input_buffer;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          srst_n = 1'b0;
    logic          axiValid = 1'b0;
    logic [DW-1:0] axiDataIn = '0;
    logic          axiReady;
    logic          dataOutValid;
    logic [DW-1:0] dataOut;
    logic          dataOutStop = 1'b0;
`ifdef AXI_INPUT_BUFFER_LEVEL_EN
    logic [AW:0]   fillLevel;
`endif

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model: a word queue plus the registered ready flag.
    logic [DW-1:0] q[$];
    logic          mReady = 1'b0;
    logic [DW-1:0] mLast  = '0;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          s;
        logic          eReady;
        logic          eValid;
        logic [DW-1:0] eData;
        logic [AW:0]   eLevel;
    } vec_t;

    vec_t tbl[12];

    always #5 clk = ~clk;

    axi_input_buffer #(
        .DataWidth(DW),
        .AddrWidth(AW)
    ) dut (
        .clk         (clk),
        .srst_n      (srst_n),
        .axiValid    (axiValid),
        .axiDataIn   (axiDataIn),
        .axiReady    (axiReady),
        .dataOutValid(dataOutValid),
        .dataOut     (dataOut),
`ifdef AXI_INPUT_BUFFER_LEVEL_EN
        .fillLevel   (fillLevel),
`endif
        .dataOutStop (dataOutStop)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_check(input string tag);
        logic [DW-1:0] expData;
        expData = (q.size() != 0) ? q[0] : mLast;
        check({tag, "_axiReady"}, 32'(axiReady), 32'(mReady));
        check({tag, "_dataOutValid"}, 32'(dataOutValid), 32'(q.size() != 0));
        check({tag, "_dataOut"}, 32'(dataOut), 32'(expData));
`ifdef AXI_INPUT_BUFFER_LEVEL_EN
        check({tag, "_fillLevel"}, 32'(fillLevel), 32'(q.size()));
`endif
        if (q.size() != 0) mLast = q[0];
    endtask

    // Apply one cycle of inputs, advance the model, land #1 after the next rising edge.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic s);
        logic push;
        logic pop;
        axiValid    = v;
        axiDataIn   = d;
        dataOutStop = s;
        push = v && mReady;
        pop  = (q.size() != 0) && !s;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(d);
        mReady = q.size() < DEPTH;
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        srst_n = 1'b1;
        @(posedge clk);
        #1;
        mReady = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int cyc;

        // Directed table: single word, fill to full with stop, drain in order.
        tbl[0]  = '{1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234, 3'd1};
        tbl[2]  = '{1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h1234, 3'd0};
        tbl[3]  = '{1'b1, 16'h0002, 1'b1, 1'b1, 1'b1, 16'h0001, 3'd1};
        tbl[4]  = '{1'b1, 16'h0003, 1'b1, 1'b1, 1'b1, 16'h0001, 3'd2};
        tbl[5]  = '{1'b1, 16'h0004, 1'b1, 1'b1, 1'b1, 16'h0001, 3'd3};
        tbl[6]  = '{1'b1, 16'h0005, 1'b1, 1'b0, 1'b1, 16'h0001, 3'd4};
        tbl[7]  = '{1'b1, 16'h0005, 1'b0, 1'b0, 1'b1, 16'h0001, 3'd4};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0002, 3'd3};
        tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0003, 3'd2};
        tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0004, 3'd1};
        tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0004, 3'd0};

        // Held in reset: outputs cleared.
        srst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_axiReady", 32'(axiReady), 32'd0);
        check("rst_dataOutValid", 32'(dataOutValid), 32'd0);
        check("rst_dataOut", 32'(dataOut), 32'd0);
        release_reset();

        for (int i = 0; i < 12; i++) begin
            check($sformatf("tbl%0d_axiReady", i), 32'(axiReady), 32'(tbl[i].eReady));
            check($sformatf("tbl%0d_dataOutValid", i), 32'(dataOutValid), 32'(tbl[i].eValid));
            check($sformatf("tbl%0d_dataOut", i), 32'(dataOut), 32'(tbl[i].eData));
`ifdef AXI_INPUT_BUFFER_LEVEL_EN
            check($sformatf("tbl%0d_fillLevel", i), 32'(fillLevel), 32'(tbl[i].eLevel));
`endif
            if (q.size() != 0) mLast = q[0];
            drive(tbl[i].v, tbl[i].d, tbl[i].s);
        end

        // Streaming: valid held high, stop alternating 1,0, random data.
        accepted = 0;
        cyc = 0;
        while (accepted < 1000 && cyc < 5000) begin
            model_check("stream");
            if (mReady) accepted++;
            drive(1'b1, DW'($urandom), (cyc % 2) == 0);
            cyc++;
        end
        check("stream_accepted", 32'(accepted), 32'd1000);
        repeat (6) begin
            model_check("drain");
            drive(1'b0, '0, 1'b0);
        end

        // Fully random valid/stop mix.
        repeat (400) begin
            model_check("rand");
            drive(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
        end
        repeat (6) begin
            model_check("drain2");
            drive(1'b0, '0, 1'b0);
        end

        // Wrap: ten words through, then three buffered under stop, then async reset.
        for (int i = 0; i < 10; i++) begin
            model_check("wrap");
            drive(1'b1, DW'(16'hA000 + i), 1'b0);
        end
        model_check("wrap_tail");
        drive(1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            model_check("hold");
            drive(1'b1, DW'(16'hC000 + i), 1'b1);
        end
        model_check("pre_reset");
        axiValid  = 1'b0;
        axiDataIn = '0;
        #2;
        srst_n = 1'b0;
        #1;
        check("midrst_axiReady", 32'(axiReady), 32'd0);
        check("midrst_dataOutValid", 32'(dataOutValid), 32'd0);
        check("midrst_dataOut", 32'(dataOut), 32'd0);
        q.delete();
        mReady = 1'b0;
        mLast  = '0;
        dataOutStop = 1'b0;
        release_reset();
        model_check("post_reset");
        drive(1'b1, 16'hBEEF, 1'b0);
        check("first_after_reset", 32'(dataOut), 32'h0000BEEF);
        model_check("post_reset_word");
        drive(1'b0, '0, 1'b0);
        model_check("post_reset_empty");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
